// File: rtl/systolic_pkg.sv
// systolic_pkg: shared scheduler state encoding and default tile limits
package systolic_pkg;
    localparam int MAX_TILES_DEFAULT = 16;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DONE
    } sched_state_t;
endpackage

// File: rtl/systolic_ws_tile_sched_if.sv
// systolic_ws_tile_sched_if: command, weight-load, array-start and tile-index bundle
interface systolic_ws_tile_sched_if #(parameter int W = 4) ();
    logic         cmd_val;
    logic         cmd_rdy;
    logic [W-1:0] cmd_m_last;
    logic [W-1:0] cmd_k_last;
    logic [W-1:0] cmd_n_last;
    logic         wload_val;
    logic         wload_rdy;
    logic         arr_val;
    logic         arr_rdy;
    logic [W-1:0] m_idx;
    logic [W-1:0] k_idx;
    logic [W-1:0] n_idx;
    logic         acc_first;
    logic         busy;
    logic         done;
    modport slave (
        input  cmd_val, cmd_m_last, cmd_k_last, cmd_n_last, wload_rdy, arr_rdy,
        output cmd_rdy, wload_val, arr_val, m_idx, k_idx, n_idx, acc_first, busy, done
    );
    modport master (
        output cmd_val, cmd_m_last, cmd_k_last, cmd_n_last, wload_rdy, arr_rdy,
        input  cmd_rdy, wload_val, arr_val, m_idx, k_idx, n_idx, acc_first, busy, done
    );
endinterface

// File: rtl/systolic_tile_iter.sv
// systolic_tile_iter: m-inner, k-middle, n-outer tile counter with latched limits
module systolic_tile_iter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] m_last_in,
    input  logic [W-1:0] k_last_in,
    input  logic [W-1:0] n_last_in,
    output logic [W-1:0] m_idx,
    output logic [W-1:0] k_idx,
    output logic [W-1:0] n_idx,
    output logic         m_wrap,
    output logic         k_wrap,
    output logic         n_wrap
);
    logic [W-1:0] m_last, k_last, n_last;
    assign m_wrap = m_idx == m_last;
    assign k_wrap = k_idx == k_last;
    assign n_wrap = n_idx == n_last;
    // latch limits on a new command; step m, carrying into k then n
    always_ff @(posedge clk) begin
        if (reset) begin
            {m_last, k_last, n_last} <= '0;
            {m_idx, k_idx, n_idx} <= '0;
        end else if (clear) begin
            m_last <= m_last_in;
            k_last <= k_last_in;
            n_last <= n_last_in;
            {m_idx, k_idx, n_idx} <= '0;
        end else if (advance) begin
            m_idx <= m_wrap ? '0 : m_idx + 1'b1;
            k_idx <= !m_wrap ? k_idx : k_wrap ? '0 : k_idx + 1'b1;
            n_idx <= !(m_wrap && k_wrap) ? n_idx : n_wrap ? '0 : n_idx + 1'b1;
        end
    end
endmodule

// File: rtl/systolic_ws_tile_sched.sv
// systolic_ws_tile_sched: sequences weight loads and array runs over a GEMM tile grid
module systolic_ws_tile_sched
    import systolic_pkg::*;
#(
    parameter int MAX_TILES = MAX_TILES_DEFAULT
) (
    input logic clk,
    input logic reset,
    systolic_ws_tile_sched_if.slave bus
);
    localparam int TILE_IDX_WIDTH = $clog2(MAX_TILES);
    sched_state_t state, state_nxt;
    logic clear, advance, m_wrap, k_wrap, n_wrap, final_tile;
    logic [TILE_IDX_WIDTH-1:0] m_idx, k_idx, n_idx;
    systolic_tile_iter #(.W(TILE_IDX_WIDTH)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .advance   (advance),
        .m_last_in (bus.cmd_m_last),
        .k_last_in (bus.cmd_k_last),
        .n_last_in (bus.cmd_n_last),
        .m_idx     (m_idx),
        .k_idx     (k_idx),
        .n_idx     (n_idx),
        .m_wrap    (m_wrap),
        .k_wrap    (k_wrap),
        .n_wrap    (n_wrap)
    );
    assign final_tile    = m_wrap && k_wrap && n_wrap;
    assign bus.m_idx     = m_idx;
    assign bus.k_idx     = k_idx;
    assign bus.n_idx     = n_idx;
    assign bus.acc_first = k_idx == '0;
    assign bus.cmd_rdy   = state == S_IDLE;
    assign bus.wload_val = state == S_WLOAD;
    assign bus.arr_val   = state == S_ISSUE;
    assign bus.busy      = state != S_IDLE;
    assign bus.done      = state == S_DONE;
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else state <= state_nxt;
    end
    // next state plus counter clear/advance strobes, applied on the same edge as the transition
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        advance   = 1'b0;
        case (state)
            S_IDLE: begin
                clear     = bus.cmd_val;
                state_nxt = bus.cmd_val ? S_WLOAD : S_IDLE;
            end
            S_WLOAD:     state_nxt = bus.wload_rdy ? S_ISSUE : S_WLOAD;
            S_ISSUE:     state_nxt = bus.arr_rdy ? S_WAIT_BUSY : S_ISSUE;
            S_WAIT_BUSY: state_nxt = bus.arr_rdy ? S_WAIT_BUSY : S_WAIT_DONE;
            S_WAIT_DONE: begin
                advance   = bus.arr_rdy && !final_tile;
                state_nxt = !bus.arr_rdy ? S_WAIT_DONE : final_tile ? S_DONE : m_wrap ? S_WLOAD : S_ISSUE;
            end
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_systolic_ws_tile_sched.sv
// tb_systolic_ws_tile_sched: randomized loader/array models checked against a nested-loop tile reference
module tb_systolic_ws_tile_sched;
    typedef struct {
        int m;
        int k;
        int n;
    } tile_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    systolic_ws_tile_sched_if #(.W(4)) bus ();
    systolic_ws_tile_sched #(.MAX_TILES(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    tile_t fq[$];
    tile_t wq[$];
    int checks = 0, errors = 0, cyc = 0;
    int wl_delay = 0, wl_cnt = 0, arr_min = 1, arr_max = 1, arr_cnt = 0;
    int rise_cyc = 0, done_cyc = 0, done_seen = 0;
    bit fired_prev = 0, prev_wl = 0;
    logic [11:0] prev_idx = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        tile_t e;
        @(negedge clk);
        cyc++;
        if (bus.done === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
        end
        if (prev_wl && bus.wload_val)
            chk("wload_idx_stable", 32'({bus.m_idx, bus.k_idx, bus.n_idx}), 32'(prev_idx));
        if (bus.wload_val) chk("no_arr_val_in_wload", 32'(bus.arr_val), 0);
        prev_wl  = bus.wload_val;
        prev_idx = {bus.m_idx, bus.k_idx, bus.n_idx};
        if (fired_prev) begin
            bus.arr_rdy = 1'b0;
            arr_cnt     = $urandom_range(arr_max, arr_min);
            fired_prev  = 0;
        end else if (arr_cnt > 0) begin
            arr_cnt--;
            if (arr_cnt == 0) begin
                bus.arr_rdy = 1'b1;
                rise_cyc    = cyc;
            end
        end
        if (bus.wload_val) begin
            wl_cnt++;
            bus.wload_rdy = wl_cnt > wl_delay;
        end else bus.wload_rdy = 1'b0;
        if (bus.wload_val && bus.wload_rdy) begin
            wl_cnt = 0;
            chk("wload_expected", 32'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
                e = wq.pop_front();
                chk("wload_kn", 32'({bus.k_idx, bus.n_idx}), 32'({e.k[3:0], e.n[3:0]}));
            end
        end
        if (bus.arr_val && bus.arr_rdy) begin
            fired_prev = 1;
            chk("fire_expected", 32'(fq.size() > 0), 1);
            if (fq.size() > 0) begin
                e = fq.pop_front();
                chk("fire_mkn", 32'({bus.m_idx, bus.k_idx, bus.n_idx}), 32'({e.m[3:0], e.k[3:0], e.n[3:0]}));
                chk("fire_acc_first", 32'(bus.acc_first), 32'(e.k == 0));
            end
        end
    endtask

    task automatic load_model(input int ml, input int kl, input int nl);
        fq.delete();
        wq.delete();
        for (int n = 0; n <= nl; n++)
            for (int k = 0; k <= kl; k++) begin
                wq.push_back('{0, k, n});
                for (int m = 0; m <= ml; m++) fq.push_back('{m, k, n});
            end
        done_seen = 0;
    endtask

    task automatic issue_cmd(input int ml, input int kl, input int nl);
        chk("cmd_rdy_idle", 32'(bus.cmd_rdy), 1);
        bus.cmd_val    = 1'b1;
        bus.cmd_m_last = ml[3:0];
        bus.cmd_k_last = kl[3:0];
        bus.cmd_n_last = nl[3:0];
        step();
        bus.cmd_val    = 1'b0;
        bus.cmd_m_last = 4'($urandom);
        bus.cmd_k_last = 4'($urandom);
        bus.cmd_n_last = 4'($urandom);
        chk("wload_val_t1", 32'(bus.wload_val), 1);
        chk("busy_t1", 32'(bus.busy), 1);
        chk("cmd_rdy_t1", 32'(bus.cmd_rdy), 0);
    endtask

    task automatic run_cmd(input int ml, input int kl, input int nl, input int wd,
                           input int amin, input int amax, input bit poke);
        int budget;
        wl_delay = wd;
        arr_min  = amin;
        arr_max  = amax;
        load_model(ml, kl, nl);
        issue_cmd(ml, kl, nl);
        if (wd == 0) begin
            step();
            chk("arr_val_t2", 32'(bus.arr_val), 1);
        end
        if (poke) begin
            repeat (6) step();
            chk("busy_before_poke", 32'(bus.busy), 1);
            bus.cmd_val    = 1'b1;
            bus.cmd_m_last = ~ml[3:0];
            bus.cmd_k_last = ~kl[3:0];
            bus.cmd_n_last = ~nl[3:0];
            step();
            bus.cmd_val = 1'b0;
        end
        budget = 100 + (ml + 1) * (kl + 1) * (nl + 1) * (amax + wd + 8);
        for (int i = 0; i < budget && done_seen == 0; i++) step();
        chk("done_seen", done_seen, 1);
        chk("fires_left", fq.size(), 0);
        chk("wloads_left", wq.size(), 0);
        chk("done_after_rise", done_cyc - rise_cyc, 1);
        chk("idx_at_done", 32'({bus.m_idx, bus.k_idx, bus.n_idx}), 32'({ml[3:0], kl[3:0], nl[3:0]}));
        step();
        chk("done_one_cycle", 32'(bus.done), 0);
        chk("cmd_rdy_back", 32'(bus.cmd_rdy), 1);
        chk("busy_idle", 32'(bus.busy), 0);
        chk("idx_hold", 32'({bus.m_idx, bus.k_idx, bus.n_idx}), 32'({ml[3:0], kl[3:0], nl[3:0]}));
        fq.delete();
        wq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_rdy"}, 32'(bus.cmd_rdy), 1);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_wload_val"}, 32'(bus.wload_val), 0);
        chk({tag, "_arr_val"}, 32'(bus.arr_val), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_idx"}, 32'({bus.m_idx, bus.k_idx, bus.n_idx}), 0);
        chk({tag, "_acc_first"}, 32'(bus.acc_first), 1);
    endtask

    initial begin
        bus.cmd_val    = 1'b0;
        bus.cmd_m_last = '0;
        bus.cmd_k_last = '0;
        bus.cmd_n_last = '0;
        bus.wload_rdy  = 1'b0;
        bus.arr_rdy    = 1'b1;
        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b0;
        run_cmd(0, 0, 0, 0, 1, 3, 0);
        run_cmd(1, 1, 1, 0, 1, 1, 0);
        run_cmd(0, 1, 0, 5, 1, 2, 0);
        run_cmd(1, 0, 1, 0, 20, 20, 0);
        run_cmd(2, 1, 1, 1, 1, 3, 1);
        repeat (6) run_cmd($urandom_range(3), $urandom_range(3), $urandom_range(3),
                           $urandom_range(3), 1, 4, 0);
        wl_delay = 0;
        arr_min  = 20;
        arr_max  = 20;
        load_model(1, 1, 1);
        issue_cmd(1, 1, 1);
        for (int i = 0; i < 500 && fq.size() > 4; i++) step();
        chk("reached_tile_110", fq.size(), 4);
        repeat (5) step();
        chk("mid_busy", 32'(bus.busy), 1);
        chk("mid_idx", 32'({bus.m_idx, bus.k_idx, bus.n_idx}), 32'(12'h110));
        reset = 1'b1;
        step();
        check_reset_outputs("midrst");
        chk("midrst_no_done", done_seen, 0);
        reset       = 1'b0;
        fq.delete();
        wq.delete();
        arr_cnt     = 0;
        fired_prev  = 0;
        wl_cnt      = 0;
        bus.arr_rdy = 1'b1;
        run_cmd(1, 0, 0, 0, 1, 2, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_ws_tile_sched.md
# systolic_ws_tile_sched

Tile scheduler that runs a full GEMM on the weight-stationary systolic array by sequencing it over a grid of tiles. It accepts one command giving the tile counts along M (source rows), K (reduction length) and N (result columns). For each (k,n) weight tile it requests a weight load, then starts the array control path once per M tile, waiting for each run to finish. It sits between the host/command interface and the array control path's val_in/rdy_in handshake, and drives tile indices to the SRAM address generators.

## Interface
Parameters:
- MAX_TILES, 16, maximum tiles per dimension
- TILE_IDX_WIDTH, $clog2(MAX_TILES), derived; not set manually

Ports (clock and reset first):
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- cmd_val  in  1  command valid
- cmd_rdy  out  1  scheduler can accept a command
- cmd_m_last  in  TILE_IDX_WIDTH  number of M tiles minus 1
- cmd_k_last  in  TILE_IDX_WIDTH  number of K tiles minus 1
- cmd_n_last  in  TILE_IDX_WIDTH  number of N tiles minus 1
- wload_val  out  1  weight-load request for tile (k_idx,n_idx)
- wload_rdy  in  1  weight loader accepts / has completed the load
- arr_val  out  1  start request to array control path (to its val_in)
- arr_rdy  in  1  array control path idle (its rdy_in)
- m_idx, k_idx, n_idx  out  TILE_IDX_WIDTH each  current tile indices
- acc_first  out  1  high when k_idx==0; the result write overwrites instead of accumulating
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the command has completed

## Operation
- States: IDLE, WLOAD, ISSUE, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE: cmd_rdy=1. On cmd_val, latch the three *_last fields, clear m/k/n indices to 0, and go to WLOAD.
- WLOAD: wload_val=1. Hold until wload_rdy; then go to ISSUE.
- ISSUE: arr_val=1. Hold until arr_rdy (the fire cycle); then go to WAIT_BUSY.
- WAIT_BUSY: when arr_rdy==0 (array has started), go to WAIT_DONE.
- WAIT_DONE: when arr_rdy==1 (array has returned to idle), advance the loop:
  - If m_idx<m_last: m_idx+1, then go to ISSUE. Weights stay resident.
  - Else if k_idx<k_last: m_idx=0, k_idx+1, then go to WLOAD.
  - Else if n_idx<n_last: m_idx=0, k_idx=0, n_idx+1, then go to WLOAD.
  - Else go to DONE.
- Loop order: n outermost, k middle, m innermost. This gives exactly one weight load per (k,n).
- DONE: done=1 for one cycle, then go to IDLE. Indices hold their last values until the next command.
- acc_first is combinational: (k_idx==0).
- Index widths: comparisons are unsigned against the latched *_last values. No wrap-around is possible, because the increment happens only when idx<last.
- Total runs = (m_last+1)(k_last+1)(n_last+1). Total weight loads = (k_last+1)(n_last+1).
- cmd_val outside IDLE is ignored. No queueing is provided.
- Reset, including mid-operation: go to IDLE immediately. Outputs then reset to: cmd_rdy=1, wload_val=0, arr_val=0, busy=0, done=0, all indices 0, acc_first=1, latched *_last=0. An in-flight array run is not tracked after reset; the array control path must be reset together with the scheduler.

## Timing
- All control outputs are Moore, decoded from registered state. Indices are registered.
- Command accepted at cycle t → wload_val=1 at t+1.
- With wload_rdy and arr_rdy both held high: arr_val=1 at t+2 (fire), WAIT_BUSY at t+3.
- Next ISSUE is one cycle after the first WAIT_DONE cycle that sees arr_rdy==1.
- Index updates and the state change take effect on the same clock edge. arr_val and wload_val therefore always see indices that are stable for the whole request.
- Valid/ready: val is held until rdy is seen. A source never drops val without a handshake.

## Structure
- Shared package systolic_pkg holds the sched_state_t enum (6 states, 3 bits) and MAX_TILES_DEFAULT.
- One sub-module, systolic_tile_iter:
  - Three-level nested counter with the m/k/n registers and clear/advance inputs.
  - Outputs m_wrap, k_wrap and last flags.
- The FSM stays in systolic_ws_tile_sched.

## Test plan
- Single tile (all *_last=0), ready inputs high:
  - 1 wload at (k0,n0), 1 arr fire with acc_first=1.
  - done pulse 1 cycle after arr_rdy returns high.
  - cmd_rdy back to 1.
- m_last=1, k_last=1, n_last=1:
  - Fire order (m,k,n): (0,0,0) (1,0,0) (0,1,0) (1,1,0) (0,0,1) (1,0,1) (0,1,1) (1,1,1).
  - wload count = 4.
  - acc_first=1 only on fires with k=0.
- wload_rdy held low 5 cycles in WLOAD: wload_val stays 1 with indices stable; no arr_val is asserted until the handshake.
- Array model holds arr_rdy low for 20 cycles after each fire: exactly one fire per run and no double issue; the arr_rdy high at the fire cycle is not taken as done.
- cmd_val pulsed while busy, with different *_last values: ignored; the run completes using the original counts.
- reset asserted in WAIT_DONE during tile (1,1,0): next cycle state=IDLE, busy=0, indices 0, no done pulse; a new command then runs from (0,0,0).
